// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle control path.
//            Holds the FSM state codes, opcode constants, the datapath mux
//            and ALU encodings, and the immediate-format selects.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // Immediate generator format selects
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // FSM state encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_AUIPC    = 4'd13;
    localparam logic [3:0] S_ILLEGAL  = 4'd14;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Bundle of all per-state control outputs
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

endpackage : multicycle_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_opdecode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_opdecode
// Purpose  : Combinational opcode classifier. Maps the instruction opcode to
//            the state entered after DECODE and flags unsupported opcodes.
// Ports    : op_i          [6:0] opcode from the instruction register
//            next_state_o  [3:0] post-DECODE state
//            illegal_o           opcode is not a supported RV32I opcode
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [3:0] next_state_o,
    output logic       illegal_o
);

    always_comb begin
        next_state_o = S_ILLEGAL;
        illegal_o    = 1'b0;
        case (op_i)
            OP_LOAD,
            OP_STORE:  next_state_o = S_MEMADR;
            OP_OP:     next_state_o = S_EXECR;
            OP_OPIMM:  next_state_o = S_EXECI;
            OP_BRANCH: next_state_o = S_BRANCH;
            OP_JAL:    next_state_o = S_JAL;
            OP_JALR:   next_state_o = S_JALR;
            OP_LUI:    next_state_o = S_LUI;
            OP_AUIPC:  next_state_o = S_AUIPC;
            default: begin
                next_state_o = S_ILLEGAL;
                illegal_o    = 1'b1;
            end
        endcase
    end

endmodule : ctrl_opdecode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the RV32I multi-cycle core. Sequences each
//            instruction through fetch/decode/execute/memory/writeback and
//            drives every datapath enable and mux select. Memory phases stall
//            on mem_ready so a single shared memory may insert wait states.
// Ports    : clk, rst           clock, synchronous active-high reset
//            op        [6:0]    opcode from instruction register
//            mem_ready          memory completes current access
//            br_taken           resolved branch condition
//            pc_write, adr_src, mem_write, ir_write, reg_write  enables
//            result_src, alu_src_a, alu_src_b, alu_op [1:0]     selects
//            imm_src   [2:0]    immediate format select
//            illegal            unsupported opcode trapped (sticky)
//            state     [3:0]    current FSM state
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    input  logic       br_taken,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] dec_next;
    logic       dec_illegal;
    ctrl_t      ctrl;

    ctrl_opdecode u_opdecode (
        .op_i         (op),
        .next_state_o (dec_next),
        .illegal_o    (dec_illegal)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = dec_illegal ? S_ILLEGAL : dec_next;
            // IR is stable here, so op still distinguishes load from store
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI,
            S_AUIPC:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            // JALR parks its target in ALUOut, then reuses JAL's link path
            S_JALR:     state_d = S_JAL;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        ctrl         = '0;
        ctrl.imm_src = IMM_I;
        case (state_q)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                // PC advances only when the fetch really completes
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch/JAL target into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.imm_src   = IMM_I;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = br_taken;
            end
            S_JALR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = IMM_I;
            end
            S_JAL: begin
                // PC takes the ALUOut target while the ALU forms oldPC+4
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl         = '0;
                ctrl.imm_src = IMM_I;
            end
        endcase
    end

    // Architectural write strobes are suppressed while rst is asserted,
    // even though the state register still shows the pre-reset state.
    assign pc_write   = ctrl.pc_write  & ~rst;
    assign ir_write   = ctrl.ir_write  & ~rst;
    assign mem_write  = ctrl.mem_write & ~rst;
    assign reg_write  = ctrl.reg_write & ~rst;
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign imm_src    = ctrl.imm_src;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule : multicycle_ctrl
`default_nettype wire
